// File: rtl/l2_tcdm_arbiter.sv
// Round-robin arbiter sharing one L2 TCDM slave port between NB_MASTERS masters,
// with optional per-master burst lock and fixed-latency response routing.
module l2_tcdm_arbiter #(
    parameter int NB_MASTERS   = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BE_WIDTH     = DATA_WIDTH / 8,
    parameter int RESP_LATENCY = 1,
    parameter int ID_W         = $clog2(NB_MASTERS)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NB_MASTERS-1:0]            m_req_i,
    input  logic [NB_MASTERS-1:0]            m_lock_i,
    input  logic [NB_MASTERS*ADDR_WIDTH-1:0] m_add_i,
    input  logic [NB_MASTERS-1:0]            m_wen_i,
    input  logic [NB_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    input  logic [NB_MASTERS*BE_WIDTH-1:0]   m_be_i,
    output logic [NB_MASTERS-1:0]            m_gnt_o,
    output logic [NB_MASTERS*DATA_WIDTH-1:0] m_r_rdata_o,
    output logic [NB_MASTERS-1:0]            m_r_valid_o,
    output logic                             s_req_o,
    output logic [ADDR_WIDTH-1:0]            s_add_o,
    output logic                             s_wen_o,
    output logic [DATA_WIDTH-1:0]            s_wdata_o,
    output logic [BE_WIDTH-1:0]              s_be_o,
    input  logic                             s_gnt_i,
    input  logic [DATA_WIDTH-1:0]            s_r_rdata_i
);

    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         rr_next;
    logic [ID_W-1:0]         lock_owner;
    logic                    lock_owner_vld;
    logic [ID_W-1:0]         winner;
    logic                    found;
    logic                    handshake;
    int                      idx;
    logic [RESP_LATENCY-1:0] pipe_vld;
    logic [ID_W-1:0]         pipe_id [RESP_LATENCY];

    // A live lock owner wins outright; otherwise scan from rr_ptr with wrap.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = 0;
        if (lock_owner_vld && m_req_i[lock_owner]) begin
            winner = lock_owner;
        end else begin
            for (int i = 0; i < NB_MASTERS; i++) begin
                idx = (int'(rr_ptr) + i) % NB_MASTERS;
                if (!found && m_req_i[idx]) begin
                    winner = ID_W'(idx);
                    found  = 1'b1;
                end
            end
        end
    end

    assign handshake = m_req_i[winner] & s_gnt_i;
    assign rr_next   = (int'(winner) == NB_MASTERS - 1) ? '0 : winner + 1'b1;
    assign s_req_o   = |m_req_i;

    always_comb begin
        s_add_o   = '0;
        s_wen_o   = 1'b0;
        s_wdata_o = '0;
        s_be_o    = '0;
        if (|m_req_i) begin
            s_add_o   = m_add_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            s_wen_o   = m_wen_i[winner];
            s_wdata_o = m_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            s_be_o    = m_be_i[int'(winner)*BE_WIDTH +: BE_WIDTH];
        end
    end

    always_comb begin
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        for (int k = 0; k < NB_MASTERS; k++) begin
            m_gnt_o[k]     = (winner == ID_W'(k)) & m_req_i[k] & s_gnt_i;
            m_r_valid_o[k] = pipe_vld[RESP_LATENCY-1] & (pipe_id[RESP_LATENCY-1] == ID_W'(k));
        end
    end

    assign m_r_rdata_o = {NB_MASTERS{s_r_rdata_i}};

    // A locking handshake pins the owner without advancing rr_ptr.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr         <= '0;
            lock_owner     <= '0;
            lock_owner_vld <= 1'b0;
        end else if (handshake) begin
            if (m_lock_i[winner]) begin
                lock_owner     <= winner;
                lock_owner_vld <= 1'b1;
            end else begin
                lock_owner_vld <= 1'b0;
                rr_ptr         <= rr_next;
            end
        end else if (lock_owner_vld && !m_req_i[lock_owner]) begin
            lock_owner_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld <= '0;
            pipe_id  <= '{default: '0};
        end else begin
            pipe_vld[0] <= handshake;
            pipe_id[0]  <= winner;
            for (int i = 1; i < RESP_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

endmodule

// File: tb/tb_l2_tcdm_arbiter.sv
// Scoreboard bench for l2_tcdm_arbiter: reference arbitration model, byte-enable
// RAM model with fixed latency, and an in-order response queue.
`timescale 1ns/1ps
module tb_l2_tcdm_arbiter;

    localparam int NB  = 3;
    localparam int LAT = 2;

    logic              clk;
    logic              rst_n;
    logic [NB-1:0]     req;
    logic [NB-1:0]     lock;
    logic [NB-1:0]     wen;
    logic [31:0]       add   [NB];
    logic [31:0]       wdata [NB];
    logic [3:0]        be    [NB];
    logic [NB*32-1:0]  m_add;
    logic [NB*32-1:0]  m_wdata;
    logic [NB*4-1:0]   m_be;
    logic [NB-1:0]     m_gnt;
    logic [NB*32-1:0]  m_r_rdata;
    logic [NB-1:0]     m_r_valid;
    logic              s_req;
    logic [31:0]       s_add;
    logic              s_wen;
    logic [31:0]       s_wdata;
    logic [3:0]        s_be;
    logic              s_gnt;
    logic [31:0]       s_rdata;

    typedef struct {
        int          id;
        int          due;
        logic        rd;
        logic [31:0] data;
    } resp_t;

    resp_t       sb [$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rpipe [LAT];
    int          m_rr;
    int          m_lock_owner;
    bit          m_lock_vld;
    int          cyc;
    int          checks;
    int          errors;
    int          grant_cnt [NB];
    logic [NB-1:0] last_gnt;
    logic [NB-1:0] last_rv;
    logic [31:0]   last_rdata;

    l2_tcdm_arbiter #(
        .NB_MASTERS  (NB),
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .BE_WIDTH    (4),
        .RESP_LATENCY(LAT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .m_req_i     (req),
        .m_lock_i    (lock),
        .m_add_i     (m_add),
        .m_wen_i     (wen),
        .m_wdata_i   (m_wdata),
        .m_be_i      (m_be),
        .m_gnt_o     (m_gnt),
        .m_r_rdata_o (m_r_rdata),
        .m_r_valid_o (m_r_valid),
        .s_req_o     (s_req),
        .s_add_o     (s_add),
        .s_wen_o     (s_wen),
        .s_wdata_o   (s_wdata),
        .s_be_o      (s_be),
        .s_gnt_i     (s_gnt),
        .s_r_rdata_i (s_rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NB; k++) begin
            m_add[k*32 +: 32]   = add[k];
            m_wdata[k*32 +: 32] = wdata[k];
            m_be[k*4 +: 4]      = be[k];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] memRead(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic resetModel();
        sb.delete();
        m_rr = 0;
        m_lock_owner = 0;
        m_lock_vld = 0;
        for (int i = 0; i < LAT; i++) rpipe[i] = 32'h0;
        s_rdata = 32'h0;
    endtask

    // One bus cycle: drive, check combinational outputs and due responses, then model the edge.
    task automatic applyStimulus(input logic [NB-1:0] r, input logic [NB-1:0] lk, input logic sg);
        int          w;
        bit          found;
        bit          hs;
        logic [NB-1:0] exp_gnt;
        logic [NB-1:0] exp_rv;
        logic [31:0] rd_val;
        logic [31:0] cur;
        resp_t       e;
        req = r;
        lock = lk;
        s_gnt = sg;
        #1;
        w = m_rr;
        found = 0;
        if (m_lock_vld && req[m_lock_owner]) begin
            w = m_lock_owner;
        end else begin
            for (int i = 0; i < NB; i++) begin
                int j = (m_rr + i) % NB;
                if (!found && req[j]) begin
                    w = j;
                    found = 1;
                end
            end
        end
        hs = req[w] && sg;
        exp_gnt = '0;
        if (hs) exp_gnt[w] = 1'b1;
        checkOutput("gnt", m_gnt, exp_gnt);
        checkOutput("s_req", s_req, |req);
        if (|req) begin
            checkOutput("s_add", s_add, add[w]);
            checkOutput("s_wen", s_wen, wen[w]);
            if (!wen[w]) begin
                checkOutput("s_wdata", s_wdata, wdata[w]);
                checkOutput("s_be", s_be, be[w]);
            end
        end
        last_gnt = m_gnt;
        exp_rv = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            exp_rv[e.id] = 1'b1;
            if (e.rd) checkOutput("rdata", m_r_rdata[e.id*32 +: 32], e.data);
            last_rdata = m_r_rdata[e.id*32 +: 32];
        end
        checkOutput("r_valid", m_r_valid, exp_rv);
        last_rv = m_r_valid;
        @(posedge clk);
        rd_val = 32'h0;
        if (hs) begin
            if (lock[w]) begin
                m_lock_owner = w;
                m_lock_vld = 1;
            end else begin
                m_lock_vld = 0;
                m_rr = (w + 1) % NB;
            end
            if (wen[w]) begin
                rd_val = memRead(add[w]);
            end else begin
                cur = memRead(add[w]);
                for (int b = 0; b < 4; b++)
                    if (be[w][b]) cur[b*8 +: 8] = wdata[w][b*8 +: 8];
                mem[add[w]] = cur;
            end
            sb.push_back('{id: w, due: cyc + LAT, rd: wen[w], data: rd_val});
            grant_cnt[w]++;
        end else if (m_lock_vld && !req[m_lock_owner]) begin
            m_lock_vld = 0;
        end
        for (int i = LAT - 1; i > 0; i--) rpipe[i] = rpipe[i-1];
        rpipe[0] = rd_val;
        s_rdata = rpipe[LAT-1];
        cyc++;
        @(negedge clk);
    endtask

    task automatic clearCounts();
        for (int k = 0; k < NB; k++) grant_cnt[k] = 0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clk = 0;
        rst_n = 0;
        req = '0;
        lock = '0;
        wen = '1;
        s_gnt = 0;
        cyc = 0;
        checks = 0;
        errors = 0;
        last_rdata = 32'h0;
        for (int k = 0; k < NB; k++) begin
            add[k] = 32'h1C000100 + 32'(k * 4);
            wdata[k] = 32'h0;
            be[k] = 4'hF;
        end
        clearCounts();
        resetModel();
        mem[32'h1C000010] = 32'hDEADBEEF;
        @(negedge clk);
        #1;
        checkOutput("rst_gnt", m_gnt, '0);
        checkOutput("rst_rv", m_r_valid, '0);
        checkOutput("rst_sreq", s_req, 1'b0);
        @(negedge clk);
        rst_n = 1;

        $display("[TB] single master read");
        add[1] = 32'h1C000010;
        applyStimulus(3'b010, '0, 1'b1);
        checkOutput("single_gnt", last_gnt, 3'b010);
        repeat (LAT) applyStimulus('0, '0, 1'b1);
        checkOutput("single_rv", last_rv, 3'b010);
        checkOutput("single_data", last_rdata, 32'hDEADBEEF);
        applyStimulus(3'b100, '0, 1'b1);

        $display("[TB] backpressure");
        add[0] = 32'h1C000040;
        add[1] = 32'h1C000044;
        repeat (3) begin
            applyStimulus(3'b011, '0, 1'b0);
            checkOutput("bp_nogrant", last_gnt, '0);
            checkOutput("bp_addr", s_add, 32'h1C000040);
        end
        applyStimulus(3'b011, '0, 1'b1);
        checkOutput("bp_first", last_gnt, 3'b001);

        $display("[TB] fairness");
        clearCounts();
        repeat (6) applyStimulus(3'b011, '0, 1'b1);
        checkOutput("fair_m0", grant_cnt[0], 3);
        checkOutput("fair_m1", grant_cnt[1], 3);
        applyStimulus(3'b010, '0, 1'b1);

        $display("[TB] lock");
        clearCounts();
        repeat (4) applyStimulus(3'b011, 3'b001, 1'b1);
        checkOutput("lock_m0", grant_cnt[0], 4);
        applyStimulus(3'b010, '0, 1'b1);
        checkOutput("lock_release", last_gnt, 3'b010);

        $display("[TB] write then read");
        add[0] = 32'h1C000000;
        add[1] = 32'h1C000000;
        wen[0] = 1'b0;
        wdata[0] = 32'hA5A5A5A5;
        be[0] = 4'b0011;
        applyStimulus(3'b001, '0, 1'b1);
        wen[0] = 1'b1;
        applyStimulus(3'b010, '0, 1'b1);
        repeat (LAT) applyStimulus('0, '0, 1'b1);
        checkOutput("wr_rd_data", last_rdata, 32'h0000A5A5);

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < NB; k++) begin
                add[k] = 32'h1C000000 + 32'($urandom_range(0, 3) * 4);
                wen[k] = ($urandom_range(0, 2) != 0);
                wdata[k] = $urandom;
                be[k] = 4'($urandom_range(0, 15));
            end
            applyStimulus(NB'($urandom), ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0,
                          ($urandom_range(0, 4) != 0));
        end
        wen = '1;
        repeat (LAT + 1) applyStimulus('0, '0, 1'b1);

        $display("[TB] reset mid-operation");
        applyStimulus(3'b001, '0, 1'b1);
        rst_n = 0;
        req = '0;
        lock = '0;
        resetModel();
        #1;
        checkOutput("midrst_rv", m_r_valid, '0);
        checkOutput("midrst_gnt", m_gnt, '0);
        @(negedge clk);
        rst_n = 1;
        repeat (LAT + 1) begin
            applyStimulus('0, '0, 1'b1);
            checkOutput("midrst_no_rv", last_rv, '0);
        end
        applyStimulus(3'b011, '0, 1'b1);
        checkOutput("midrst_restart", last_gnt, 3'b001);
        repeat (LAT) applyStimulus('0, '0, 1'b1);

        checkOutput("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
